// File: rtl/store_size_ctrl.sv
// -----------------------------------------------------------------------------
// store_size_ctrl
//
// Store-side data-memory sequencer for sw/sh/sb. Word stores write straight
// through; half and byte stores read the aligned word, replace the selected
// little-endian lane with the store data and write the merged word back.
// Requests use a start/busy/done handshake.
//
// Optional feature macro: STORE_ALIGN_CHECK_EN
//   defined   : misaligned sw (addr[1:0]!=0) or sh (addr[0]=1) is rejected
//               with done+err and no memory access.
//   undefined : sw ignores addr[1:0], sh ignores addr[0]; err is raised only
//               for the reserved StoreSize encoding.
//
// Parameters
//   MEM_RD_LAT  cycles from mem_addr valid to mem_rdata valid (1..7)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   start      in   store request, sampled only while idle
//   StoreSize  in   2'b00 sw, 2'b01 sh, 2'b10 sb, 2'b11 reserved
//   in_addr    in   byte address
//   in_regB    in   store data (sh uses [15:0], sb uses [7:0])
//   mem_rdata  in   data-memory read data
//   mem_addr   out  word-aligned address of the latched request
//   mem_wr     out  single-cycle write strobe
//   mem_wdata  out  write data, qualified only by mem_wr
//   busy       out  high whenever an operation is in progress
//   done       out  one-cycle completion pulse
//   err        out  one-cycle pulse with done on a rejected request
// -----------------------------------------------------------------------------
module store_size_ctrl #(
   parameter int MEM_RD_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  StoreSize,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_regB,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;

   localparam logic [2:0] LAT_LAST = 3'(MEM_RD_LAT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_FAIL  = 2'd3
   } state_t;

   state_t      state, state_next;
   logic [2:0]  lat_cnt;
   logic [1:0]  size_q;
   logic [1:0]  off_q;
   logic [31:0] regb_q;
   logic        accept;
   logic        read_last;

   // Replace the addressed lane of the memory word with the store data.
   function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
      logic [31:0] res;
      res = word;
      if (size == SZ_HALF) begin
         if (off[1]) res[31:16] = data[15:0];
         else        res[15:0]  = data[15:0];
      end else begin
         case (off)
            2'd0:    res[7:0]   = data[7:0];
            2'd1:    res[15:8]  = data[7:0];
            2'd2:    res[23:16] = data[7:0];
            default: res[31:24] = data[7:0];
         endcase
      end
      return res;
   endfunction

`ifdef STORE_ALIGN_CHECK_EN
   // Byte stores can never be misaligned.
   function automatic logic misaligned(input logic [1:0] size,
                                       input logic [1:0] off);
      logic bad;
      bad = 1'b0;
      if (size == SZ_WORD)      bad = (off != 2'b00);
      else if (size == SZ_HALF) bad = off[0];
      return bad;
   endfunction
`endif

   assign accept    = (state == ST_IDLE) && start;
   assign read_last = (state == ST_READ) && (lat_cnt == LAT_LAST);

   // Next-state logic and Moore outputs; strobes derive from state so an
   // asynchronous reset removes them within the same cycle.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      mem_wr     = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               case (StoreSize)
                  SZ_WORD: state_next = ST_WRITE;
                  SZ_HALF: state_next = ST_READ;
                  SZ_BYTE: state_next = ST_READ;
                  default: state_next = ST_FAIL;
               endcase
`ifdef STORE_ALIGN_CHECK_EN
               if (misaligned(StoreSize, in_addr[1:0])) state_next = ST_FAIL;
`endif
            end
         end
         ST_READ: begin
            busy = 1'b1;
            if (lat_cnt == LAT_LAST) state_next = ST_WRITE;
         end
         ST_WRITE: begin
            busy       = 1'b1;
            mem_wr     = 1'b1;
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         ST_FAIL: begin
            busy       = 1'b1;
            done       = 1'b1;
            err        = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Read-latency counter: cleared on entry to READ, counts while reading.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                     lat_cnt <= 3'd0;
      else if (state_next == ST_READ && state != ST_READ) lat_cnt <= 3'd0;
      else if (state == ST_READ)      lat_cnt <= lat_cnt + 3'd1;
   end

   // The word address is held from the accepted start until the next one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      mem_addr <= 32'd0;
      else if (accept) mem_addr <= {in_addr[31:2], 2'b00};
   end

   // Write data is prepared on the edge entering WRITE and then held.
   // Word stores take the incoming data directly; half/byte stores merge
   // into the read word sampled on the final READ cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         mem_wdata <= 32'd0;
      else if (accept && state_next == ST_WRITE)
         mem_wdata <= in_regB;
      else if (read_last)
         mem_wdata <= merge_lane(mem_rdata, regb_q, size_q, off_q);
   end

   // Request operands, frozen for the duration of the operation.
   always_ff @(posedge clk) begin
      if (accept) begin
         size_q <= StoreSize;
         off_q  <= in_addr[1:0];
         regb_q <= in_regB;
      end
   end

endmodule

// File: tb/tb_store_size_ctrl.sv
// -----------------------------------------------------------------------------
// tb_store_size_ctrl
//
// Drives two instances of store_size_ctrl (read latency 1 and 3) with the
// same request stream. Each instance sees a memory that presents the true
// read word only in the cycle it must be captured, and a poison value at
// all other times. A vector table covers the store sizes and lanes; hand
// sequences cover reset in READ and reset during the write cycle.
// -----------------------------------------------------------------------------
module tb_store_size_ctrl;

   localparam logic [31:0] GARB = 32'hBAD0_BAD0;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] regb;
   logic [31:0] rd1, rd3;
   logic [31:0] maddr1, maddr3, wdata1, wdata3;
   logic        wr1, wr3, busy1, busy3, done1, done3, err1, err3;

   int errors = 0;
   int checks = 0;

   store_size_ctrl #(.MEM_RD_LAT(1)) dut1 (
      .clk(clk), .reset(rst), .start(start), .StoreSize(size),
      .in_addr(addr), .in_regB(regb), .mem_rdata(rd1),
      .mem_addr(maddr1), .mem_wr(wr1), .mem_wdata(wdata1),
      .busy(busy1), .done(done1), .err(err1)
   );

   store_size_ctrl #(.MEM_RD_LAT(3)) dut3 (
      .clk(clk), .reset(rst), .start(start), .StoreSize(size),
      .in_addr(addr), .in_regB(regb), .mem_rdata(rd3),
      .mem_addr(maddr3), .mem_wr(wr3), .mem_wdata(wdata3),
      .busy(busy3), .done(done3), .err(err3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  sz;
      logic [31:0] addr;
      logic [31:0] regb;
      logic [31:0] rdata;
      bit          sel3;
      int          pulse_cyc;
      bit          exp_wr;
      int          exp_cyc;
      logic [31:0] exp_wdata;
      bit          exp_err;
      logic [31:0] exp_addr;
   } vec_t;

   vec_t vecs[11];

   // per-run observations of the selected instance
   int          wcnt, wcyc, dcnt, dcyc, ecnt;
   logic [31:0] wdat, addr1;
   logic        busy_c1, busy_end, err_at_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_op(input vec_t v);
      logic        o_wr, o_done, o_err, o_busy;
      logic [31:0] o_wdata, o_addr;
      wcnt = 0; wcyc = 0; dcnt = 0; dcyc = 0; ecnt = 0;
      wdat = 32'd0; addr1 = 32'd0; busy_c1 = 1'b0; busy_end = 1'b1; err_at_done = 1'b0;
      @(negedge clk);
      size  = v.sz;
      addr  = v.addr;
      regb  = v.regb;
      rd1   = GARB;
      rd3   = GARB;
      start = 1'b1;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(negedge clk);
         start = (cyc == v.pulse_cyc);
         rd1   = (cyc == 1) ? v.rdata : GARB;
         rd3   = (cyc == 3) ? v.rdata : GARB;
         o_wr    = v.sel3 ? wr3    : wr1;
         o_done  = v.sel3 ? done3  : done1;
         o_err   = v.sel3 ? err3   : err1;
         o_busy  = v.sel3 ? busy3  : busy1;
         o_wdata = v.sel3 ? wdata3 : wdata1;
         o_addr  = v.sel3 ? maddr3 : maddr1;
         if (cyc == 1) begin
            addr1   = o_addr;
            busy_c1 = o_busy;
         end
         if (o_wr) begin
            wcnt++;
            wcyc = cyc;
            wdat = o_wdata;
         end
         if (o_done) begin
            dcnt++;
            dcyc = cyc;
            err_at_done = o_err;
         end
         if (o_err) ecnt++;
         if (cyc == 10) busy_end = o_busy;
      end
   endtask

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      size  = 2'b00;
      addr  = 32'd0;
      regb  = 32'd0;
      rd1   = GARB;
      rd3   = GARB;

      //            sz     addr          regb          rdata         sel3 pulse wr cyc wdata         err addr
      vecs[0]  = '{2'b00, 32'h0000_0104, 32'hDEAD_BEEF, GARB,         0, 0, 1, 1, 32'hDEAD_BEEF, 0, 32'h0000_0104};
      vecs[1]  = '{2'b10, 32'h0000_0103, 32'h0000_00AB, 32'h1122_3344, 0, 0, 1, 2, 32'hAB22_3344, 0, 32'h0000_0100};
      vecs[2]  = '{2'b01, 32'h0000_0102, 32'h0000_CAFE, 32'h1122_3344, 1, 0, 1, 4, 32'hCAFE_3344, 0, 32'h0000_0100};
      vecs[3]  = '{2'b11, 32'h0000_0200, 32'h1234_5678, 32'h1122_3344, 0, 0, 0, 1, 32'h0,         1, 32'h0000_0200};
`ifdef STORE_ALIGN_CHECK_EN
      vecs[4]  = '{2'b01, 32'h0000_0101, 32'h0000_CAFE, 32'h1122_3344, 0, 0, 0, 1, 32'h0,         1, 32'h0000_0100};
      vecs[8]  = '{2'b00, 32'hFFFF_FFFF, 32'h1234_5678, GARB,         1, 0, 0, 1, 32'h0,         1, 32'hFFFF_FFFC};
`else
      vecs[4]  = '{2'b01, 32'h0000_0101, 32'h0000_CAFE, 32'h1122_3344, 0, 0, 1, 2, 32'h1122_CAFE, 0, 32'h0000_0100};
      vecs[8]  = '{2'b00, 32'hFFFF_FFFF, 32'h1234_5678, GARB,         1, 0, 1, 1, 32'h1234_5678, 0, 32'hFFFF_FFFC};
`endif
      vecs[5]  = '{2'b10, 32'h0000_0100, 32'hFFFF_FF5A, 32'hA5A5_A5A5, 1, 0, 1, 4, 32'hA5A5_A55A, 0, 32'h0000_0100};
      vecs[6]  = '{2'b10, 32'h0000_0101, 32'h0000_0077, 32'h0000_0000, 0, 1, 1, 2, 32'h0000_7700, 0, 32'h0000_0100};
      vecs[7]  = '{2'b10, 32'h0000_0102, 32'h0000_0066, 32'hFFFF_FFFF, 1, 4, 1, 4, 32'hFF66_FFFF, 0, 32'h0000_0100};
      vecs[9]  = '{2'b01, 32'h0000_0100, 32'h0000_BEEF, 32'h1122_3344, 1, 2, 1, 4, 32'h1122_BEEF, 0, 32'h0000_0100};
      vecs[10] = '{2'b00, 32'h0000_0008, 32'hA5A5_0F0F, GARB,         0, 1, 1, 1, 32'hA5A5_0F0F, 0, 32'h0000_0008};

      // reset state, observed while reset is held
      repeat (3) @(negedge clk);
      chk("reset_outputs_dut1", {maddr1, wdata1[0], wr1, busy1, done1, err1} == 37'd0 ? 32'd0 : 32'd1, 32'd0);
      chk("reset_outputs_dut3", {maddr3 | wdata3}, 32'd0);
      chk("reset_strobes_dut3", {28'd0, wr3, busy3, done3, err3}, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         run_op(vecs[i]);
         chk($sformatf("v%0d_addr", i),      addr1, vecs[i].exp_addr);
         chk($sformatf("v%0d_busy_c1", i),   {31'd0, busy_c1}, 32'd1);
         chk($sformatf("v%0d_writes", i),    wcnt, vecs[i].exp_wr ? 1 : 0);
         if (vecs[i].exp_wr) begin
            chk($sformatf("v%0d_wr_cycle", i), wcyc, vecs[i].exp_cyc);
            chk($sformatf("v%0d_wdata", i),    wdat, vecs[i].exp_wdata);
         end
         chk($sformatf("v%0d_done_cnt", i),  dcnt, 1);
         chk($sformatf("v%0d_done_cyc", i),  dcyc, vecs[i].exp_cyc);
         chk($sformatf("v%0d_err_done", i),  {31'd0, err_at_done}, {31'd0, vecs[i].exp_err});
         chk($sformatf("v%0d_err_cnt", i),   ecnt, vecs[i].exp_err ? 1 : 0);
         chk($sformatf("v%0d_idle_end", i),  {31'd0, busy_end}, 32'd0);
      end

      // reset asserted while dut3 is in READ: everything clears at once
      @(negedge clk);
      size = 2'b10; addr = 32'h0000_0100; regb = 32'h0000_0011; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("rst_read_busy_before", {31'd0, busy3}, 32'd1);
      rst = 1'b0;
      #1;
      chk("rst_read_addr", maddr3, 32'd0);
      chk("rst_read_wdata", wdata3, 32'd0);
      chk("rst_read_strobes", {28'd0, wr3, busy3, done3, err3}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      wcnt = 0; dcnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (wr3) wcnt++;
         if (done3) dcnt++;
      end
      chk("rst_read_no_write", wcnt, 0);
      chk("rst_read_no_done", dcnt, 0);

      // reset asserted during the word-store write cycle drops mem_wr and done
      @(negedge clk);
      size = 2'b00; addr = 32'h0000_0040; regb = 32'h5555_AAAA; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("rst_write_wr_before", {31'd0, wr1}, 32'd1);
      rst = 1'b0;
      #1;
      chk("rst_write_wr_after", {30'd0, wr1, done1}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_write_idle", {30'd0, busy1, wr1}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
